// File: rtl/full_calc_core.sv
// Control unit and datapath of a 4-bit calculator: one-shot small ALU
// (add/sub/and/xor) or a 4-step restoring divider, result written as two nibbles.
module full_calc_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       Go,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [2:0] Op,
    output logic [3:0] H_Out,
    output logic [3:0] L_Out,
    output logic       Done,
    output logic       div_Err,
    output logic [3:0] CS,
    output logic [2:0] F_Q
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_DECODE   = 4'd1,
        S_SC_RUN   = 4'd2,
        S_SC_WAIT  = 4'd3,
        S_DIV_RUN  = 4'd4,
        S_DIV_WAIT = 4'd5,
        S_DIV_ERR  = 4'd6,
        S_WRITE    = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  x_q, x_d;
    logic [3:0]  y_q, y_d;
    logic [2:0]  fop_q, fop_d;
    logic [3:0]  h_q, h_d;
    logic [3:0]  l_q, l_d;
    logic        err_q, err_d;
    logic [7:0]  sc_res_q, sc_res_d;
    logic [3:0]  rem_q, rem_d;
    logic [3:0]  quo_q, quo_d;
    logic [1:0]  cnt_q, cnt_d;

    logic        load_ops;
    logic        sm_calc_go;
    logic        div_go;
    logic        div_step;
    logic        div_done;
    logic        out_en;
    logic        set_err;
    logic [1:0]  sel_h, sel_l;

    // Control FSM: next state and one-cycle strobes
    always_comb begin
        state_d    = state_q;
        load_ops   = 1'b0;
        sm_calc_go = 1'b0;
        div_go     = 1'b0;
        div_step   = 1'b0;
        div_done   = 1'b0;
        out_en     = 1'b0;
        set_err    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Go) begin
                    load_ops = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (fop_q <= 3'd3)      state_d = S_SC_RUN;
                else if (fop_q == 3'd4) state_d = (y_q != 4'd0) ? S_DIV_RUN : S_DIV_ERR;
                else                    state_d = S_WRITE;
            end
            S_SC_RUN: begin
                sm_calc_go = 1'b1;
                state_d    = S_SC_WAIT;
            end
            S_SC_WAIT:  state_d = S_WRITE;
            S_DIV_RUN: begin
                div_go  = 1'b1;
                state_d = S_DIV_WAIT;
            end
            S_DIV_WAIT: begin
                div_step = 1'b1;
                if (cnt_q == 2'd3) begin
                    div_done = 1'b1;
                    state_d  = S_WRITE;
                end
            end
            S_DIV_ERR: begin
                set_err = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                out_en  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!Go) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand/opcode latch and error flag
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        fop_d = fop_q;
        err_d = err_q;
        if (load_ops) begin
            x_d   = A;
            y_d   = B;
            fop_d = Op;
            err_d = 1'b0;
        end
        if (set_err) err_d = 1'b1;
    end

    // Small ALU, registered at the end of SC_RUN
    always_comb begin
        logic [4:0] sum;
        sum      = {1'b0, x_q} + {1'b0, y_q};
        sc_res_d = sc_res_q;
        if (sm_calc_go) begin
            case (fop_q)
                3'd0:    sc_res_d = {3'b000, sum[4], sum[3:0]};
                3'd1:    sc_res_d = {(x_q < y_q) ? 4'h1 : 4'h0, x_q - y_q};
                3'd2:    sc_res_d = {4'h0, x_q & y_q};
                3'd3:    sc_res_d = {4'h0, x_q ^ y_q};
                default: sc_res_d = '0;
            endcase
        end
    end

    // Restoring divider; the shifted partial remainder needs a 5th bit before the compare
    always_comb begin
        logic [4:0] rem_sh;
        rem_sh = {rem_q, quo_q[3]};
        rem_d  = rem_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        if (div_go) begin
            rem_d = '0;
            quo_d = x_q;
            cnt_d = '0;
        end else if (div_step) begin
            if (rem_sh >= {1'b0, y_q}) begin
                rem_d = 4'(rem_sh - {1'b0, y_q});
                quo_d = {quo_q[2:0], 1'b1};
            end else begin
                rem_d = rem_sh[3:0];
                quo_d = {quo_q[2:0], 1'b0};
            end
            cnt_d = cnt_q + 2'd1;
        end
    end

    // Output selects: 0 zero, 1 small ALU, 2 quotient, 3 remainder
    always_comb begin
        sel_h = 2'd0;
        sel_l = 2'd0;
        if (fop_q <= 3'd3) begin
            sel_h = 2'd1;
            sel_l = 2'd1;
        end else if (fop_q == 3'd4 && !err_q) begin
            sel_h = 2'd3;
            sel_l = 2'd2;
        end
        h_d = h_q;
        l_d = l_q;
        if (out_en) begin
            case (sel_h)
                2'd1:    h_d = sc_res_q[7:4];
                2'd2:    h_d = quo_q;
                2'd3:    h_d = rem_q;
                default: h_d = '0;
            endcase
            case (sel_l)
                2'd1:    l_d = sc_res_q[3:0];
                2'd2:    l_d = quo_q;
                2'd3:    l_d = rem_q;
                default: l_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            fop_q    <= '0;
            err_q    <= 1'b0;
            sc_res_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            h_q      <= '0;
            l_q      <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            fop_q    <= fop_d;
            err_q    <= err_d;
            sc_res_q <= sc_res_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            h_q      <= h_d;
            l_q      <= l_d;
        end
    end

    assign H_Out   = h_q;
    assign L_Out   = l_q;
    assign Done    = (state_q == S_DONE);
    assign div_Err = err_q;
    assign CS      = state_q;
    assign F_Q     = fop_q;

endmodule

// File: tb/tb_full_calc_core.sv
// Scoreboard bench for full_calc_core: driver queues expected results,
// a negedge monitor checks each Done rising edge against the queue.
module tb_full_calc_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       Go;
    logic [3:0] A, B;
    logic [2:0] Op;
    logic [3:0] H_Out, L_Out, CS;
    logic       Done, div_Err;
    logic [2:0] F_Q;

    full_calc_core dut (
        .clk(clk), .rst(rst), .Go(Go), .A(A), .B(B), .Op(Op),
        .H_Out(H_Out), .L_Out(L_Out), .Done(Done), .div_Err(div_Err),
        .CS(CS), .F_Q(F_Q)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        logic [3:0] h;
        logic [3:0] l;
        logic       err;
        int         dcyc;
    } exp_t;

    exp_t       sbq[$];
    logic [3:0] seen[$];

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Monitor: compare every completed operation against the scoreboard
    logic done_prev = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (Done && !done_prev) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk({e.name, "_H"},       int'(H_Out),   int'(e.h));
                chk({e.name, "_L"},       int'(L_Out),   int'(e.l));
                chk({e.name, "_err"},     int'(div_Err), int'(e.err));
                chk({e.name, "_latency"}, cyc,           e.dcyc);
            end
        end
        done_prev = Done;
    end

    task automatic run_op(input string nm, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] op, input logic [3:0] h, input logic [3:0] l,
                          input logic err, input int lat, input bit hold, input bit scramble);
        exp_t e;
        int   n;
        @(negedge clk);
        A = a; B = b; Op = op; Go = 1'b1;
        @(posedge clk);
        #1;
        e.name = nm; e.h = h; e.l = l; e.err = err; e.dcyc = cyc + lat;
        sbq.push_back(e);
        seen.delete();
        @(negedge clk);
        if (!hold) Go = 1'b0;
        if (scramble) begin
            A = ~a; B = 4'h0; Op = 3'd0;
        end
        seen.push_back(CS);
        n = 0;
        while (!Done && n < 20) begin
            @(negedge clk);
            seen.push_back(CS);
            n++;
        end
        if (!Done) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (CS != 4'd0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("return_idle", int'(CS), 0);
    endtask

    initial begin
        rst = 1'b0; Go = 1'b0; A = '0; B = '0; Op = '0;
        repeat (2) @(negedge clk);
        chk("reset_CS",   int'(CS),      0);
        chk("reset_H",    int'(H_Out),   0);
        chk("reset_L",    int'(L_Out),   0);
        chk("reset_Done", int'(Done),    0);
        chk("reset_err",  int'(div_Err), 0);
        chk("reset_FQ",   int'(F_Q),     0);
        rst = 1'b1;
        @(negedge clk);

        // ADD with CS trace 1,2,3,7,8 after the Go-sampling edge
        chk("pre_add_CS", int'(CS), 0);
        run_op("add_9_8", 4'd9, 4'd8, 3'd0, 4'h1, 4'h1, 1'b0, 4, 1'b0, 1'b0);
        chk("add_trace_len", seen.size(), 5);
        if (seen.size() == 5) begin
            chk("add_cs1", int'(seen[0]), 1);
            chk("add_cs2", int'(seen[1]), 2);
            chk("add_cs3", int'(seen[2]), 3);
            chk("add_cs4", int'(seen[3]), 7);
            chk("add_cs5", int'(seen[4]), 8);
        end
        wait_idle();

        run_op("sub_3_5",  4'd3,  4'd5,  3'd1, 4'h1, 4'hE, 1'b0, 4, 1'b0, 1'b0); wait_idle();
        run_op("and_c_a",  4'hC,  4'hA,  3'd2, 4'h0, 4'h8, 1'b0, 4, 1'b0, 1'b0); wait_idle();
        run_op("xor_c_a",  4'hC,  4'hA,  3'd3, 4'h0, 4'h6, 1'b0, 4, 1'b0, 1'b0); wait_idle();
        run_op("div_13_4", 4'd13, 4'd4,  3'd4, 4'h1, 4'h3, 1'b0, 7, 1'b0, 1'b0); wait_idle();
        run_op("div_15_1", 4'd15, 4'd1,  3'd4, 4'h0, 4'hF, 1'b0, 7, 1'b0, 1'b0); wait_idle();

        run_op("div_7_0",  4'd7,  4'd0,  3'd4, 4'h0, 4'h0, 1'b1, 3, 1'b0, 1'b0);
        chk("div0_trace_len", seen.size(), 4);
        if (seen.size() == 4) begin
            chk("div0_cs1", int'(seen[0]), 1);
            chk("div0_cs2", int'(seen[1]), 6);
            chk("div0_cs3", int'(seen[2]), 7);
            chk("div0_cs4", int'(seen[3]), 8);
        end
        wait_idle();
        run_op("add_clr_err", 4'd2, 4'd3, 3'd0, 4'h0, 4'h5, 1'b0, 4, 1'b0, 1'b0); wait_idle();

        run_op("op6", 4'd9, 4'd9, 3'd6, 4'h0, 4'h0, 1'b0, 2, 1'b0, 1'b0);
        chk("op6_FQ", int'(F_Q), 6);
        wait_idle();

        // Go held through DONE keeps Done asserted
        run_op("xor_hold", 4'd5, 4'd3, 3'd3, 4'h0, 4'h6, 1'b0, 4, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("hold_Done", int'(Done), 1);
        chk("hold_CS",   int'(CS),   8);
        Go = 1'b0;
        @(negedge clk);
        chk("release_Done", int'(Done), 0);
        chk("release_CS",   int'(CS),   0);

        // Inputs changed mid-divide must not affect the latched operands
        run_op("div_14_3_scr", 4'd14, 4'd3, 3'd4, 4'h2, 4'h4, 1'b0, 7, 1'b0, 1'b1); wait_idle();

        // Asynchronous reset in DIV_WAIT
        @(negedge clk);
        A = 4'd9; B = 4'd2; Op = 3'd4; Go = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Go = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_rst_CS", int'(CS), 5);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_CS",   int'(CS),      0);
        chk("arst_H",    int'(H_Out),   0);
        chk("arst_L",    int'(L_Out),   0);
        chk("arst_Done", int'(Done),    0);
        chk("arst_err",  int'(div_Err), 0);
        chk("arst_FQ",   int'(F_Q),     0);
        @(negedge clk);
        rst = 1'b1;
        run_op("sub_after_rst", 4'd9, 4'd4, 3'd1, 4'h0, 4'h5, 1'b0, 4, 1'b0, 1'b0); wait_idle();

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
